// File: rtl/_nor_serial.sv
// Bit-serial NOR reducer: accepts INPUT_WIDTH bits one per handshake and
// presents NOR of the whole word, held until the downstream consumes it.
module _nor_serial #(
  parameter int INPUT_WIDTH = 1,
  parameter int CNT_WIDTH   = ($clog2(INPUT_WIDTH + 1) > 1) ? $clog2(INPUT_WIDTH + 1) : 1
) (
  input  logic                 clock,
  input  logic                 nReset,
  input  logic                 clear,
  input  logic                 inputBit,
  input  logic                 inputValid,
  output logic                 inputReady,
  output logic                 outputData,
  output logic                 outputValid,
  input  logic                 outputReady,
  output logic [CNT_WIDTH-1:0] bitCount
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(INPUT_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(INPUT_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_e;

  state_e                 state_q, state_d;
  logic                   acc_q, acc_d;
  logic                   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ready_q, ready_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic accept;
  logic last_bit;
  logic acc_next;

  assign accept   = (state_q == COLLECT) && inputValid && ready_q;
  assign last_bit = (cnt_q == LAST_CNT);
  assign acc_next = acc_q & ~inputBit;

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      acc_q   <= 1'b1;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: leave IDLE on the first edge, HOLD after the last bit, back on consume
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = COLLECT;
      COLLECT: if (!clear && accept && last_bit) state_d = HOLD;
      HOLD:    if (outputReady) state_d = COLLECT;
      default: state_d = IDLE;
    endcase
  end

  // Registered output / accumulator updates; clear wins over a simultaneous accept
  always_comb begin
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
    ready_d = ready_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
      end
      COLLECT: begin
        if (clear) begin
          acc_d = 1'b1;
          cnt_d = '0;
        end else if (accept) begin
          acc_d = acc_next;
          if (last_bit) begin
            data_d  = acc_next;
            valid_d = 1'b1;
            ready_d = 1'b0;
            cnt_d   = FULL_CNT;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      HOLD: begin
        if (outputReady) begin
          valid_d = 1'b0;
          data_d  = 1'b0;
          acc_d   = 1'b1;
          cnt_d   = '0;
          ready_d = 1'b1;
        end
      end
      default: begin
        ready_d = 1'b0;
      end
    endcase
  end

  assign inputReady  = ready_q;
  assign outputData  = data_q;
  assign outputValid = valid_q;
  assign bitCount    = cnt_q;

endmodule

// File: doc/_nor_serial.md
# _nor_serial

Bit-serial NOR reducer. It accepts one bit per handshake and, after INPUT_WIDTH bits, presents a single result bit equal to NOR of all received bits. The result is 1 only if every bit was 0. It is the serial counterpart of the parallel `_nor` reducer in the gate library. It sits at the end of serial links where the full word is never available in parallel, typically zero-detect on a shifted-in field.

## Interface
- INPUT_WIDTH, 1: bits per word; legal range 1..256.
- CNT_WIDTH, derived: width of the bit counter, max(1, ceil(log2(INPUT_WIDTH+1))); not overridden by users.

- clock  input  1  sole clock; all state updates on the rising edge.
- nReset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush of a partial word; ignored in HOLD.
- inputBit  input  1  serial data bit.
- inputValid  input  1  inputBit valid this cycle.
- inputReady  output  1  block accepts a bit this cycle; registered.
- outputData  output  1  NOR result; meaningful only while outputValid=1; registered.
- outputValid  output  1  result available; registered.
- outputReady  input  1  downstream consumes the result.
- bitCount  output  CNT_WIDTH  number of bits accepted in the current word; registered.

## Operation
- The reset asynchronous, active-low, from nReset; the clock is `clock`. These are fixed.
- While nReset=0, outputs are: inputReady=0, outputValid=0, outputData=0, bitCount=0, accumulator=1, state=IDLE.
- States:
  - IDLE: entered only via reset. On the first clock edge with nReset=1, go to COLLECT and set inputReady=1.
  - COLLECT: inputReady=1. An accept occurs on a cycle with inputValid=1 and inputReady=1. On accept: accumulator <= accumulator & ~inputBit, and bitCount increments.
    - When the accepted bit is bit INPUT_WIDTH-1 (bitCount==INPUT_WIDTH-1 before the edge):
      - outputData <= accumulator & ~inputBit
      - outputValid <= 1
      - inputReady <= 0
      - bitCount <= INPUT_WIDTH
      - go to HOLD.
  - HOLD: inputValid is ignored. outputData and outputValid hold stable until outputReady=1. On that edge:
    - outputValid <= 0, outputData <= 0
    - accumulator <= 1, bitCount <= 0
    - inputReady <= 1, go to COLLECT.
- clear applies in COLLECT only. It sets accumulator <= 1 and bitCount <= 0, and the state stays COLLECT. clear has priority over a simultaneous accept: that bit is dropped, not counted.
- clear in HOLD or IDLE has no effect. A pending result is never discarded by clear.
- INPUT_WIDTH=1: each accept goes straight to HOLD, with outputData = ~inputBit.
- The accumulator is 1 bit. It is cleared by any 1 bit and never re-set within a word. Early 1s do not short-circuit the word: all INPUT_WIDTH bits are always consumed.

## Timing
- Latency: outputValid rises on the edge that accepts the last bit. It is visible the cycle after the last inputValid&inputReady cycle.
- Throughput: at most one bit per cycle in COLLECT. The minimum period per word is INPUT_WIDTH+1 cycles, because HOLD lasts at least one cycle and inputReady=0 there.
- Back-to-back: outputReady held at 1 gives the pattern INPUT_WIDTH accept cycles, then 1 HOLD cycle, repeated.
- Reset mid-word or in HOLD: all state returns to reset values immediately. Partial words and unconsumed results are lost. inputReady re-asserts one edge after nReset deasserts.
- No combinational path from any input to any output.
- Handshake rules:
  - Upstream may assert inputValid regardless of inputReady. A bit is transferred only on an accept cycle.
  - Downstream may assert outputReady at any time. It only has effect in HOLD.

## Test plan
- Reset/idle, INPUT_WIDTH=4: hold nReset=0 for 3 cycles, then release. Required: all outputs 0 during reset, inputReady=1 exactly one edge after release, bitCount=0.
- All-zero word, INPUT_WIDTH=4: send bits 0,0,0,0 back-to-back with outputReady=1. Required: outputValid=1 with outputData=1 the cycle after the 4th accept, lasting 1 cycle; bitCount sequence 0,1,2,3,4,0.
- Nonzero word with stall, INPUT_WIDTH=4: send 0,1,0,0 with gaps (inputValid low 2 cycles between bits) and outputReady=0 for 5 cycles. Required: outputData=0 and outputValid=1 held stable for 5+ cycles; inputReady=0 throughout HOLD; bits offered during HOLD are not counted.
- clear mid-word, INPUT_WIDTH=4: send 1,0, then clear=1 together with a valid bit 1, then send 0,0,0,0. Required: bitCount goes to 0 on clear, the simultaneous bit is dropped, and the next result is outputData=1.
- Reset in HOLD, INPUT_WIDTH=4: complete word 0,0,0,0, then pulse nReset low before outputReady. Required: outputValid drops asynchronously and no stale result appears after release.
- INPUT_WIDTH=1: stream 1,0,0,1 with outputReady=1. Required: results 0,1,1,0, each one cycle after its accept, with inputReady toggling 1,0 per word.
